// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern engine: OFF / SOLID / BLINK / CHASE patterns
// driven from one clk prescaler, configured through a valid/ready command port.
module led_pattern_ctrl #(
    parameter int          NUM_LEDS = 4,
    parameter int unsigned TICK_DIV = 50000000,
    parameter int          SEL_W    = $clog2(NUM_LEDS)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [SEL_W-1:0]    cmd_sel,
    input  logic [3:0]          cmd_rate,
    output logic [NUM_LEDS-1:0] led,
    output logic [1:0]          mode_o
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_SOLID = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_CHASE = 2'b11
    } mode_t;

    localparam logic [31:0]      TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [SEL_W-1:0] LAST_LED  = SEL_W'(NUM_LEDS - 1);

    mode_t            cap_mode;
    mode_t            act_mode;
    logic [SEL_W-1:0] cap_sel;
    logic [SEL_W-1:0] act_sel;
    logic [SEL_W-1:0] position;
    logic [SEL_W-1:0] next_position;
    logic [SEL_W-1:0] sel_eff;
    logic [3:0]       cap_rate;
    logic [3:0]       act_rate;
    logic [3:0]       rate_eff;
    logic [3:0]       rate_cnt;
    logic [31:0]      prescaler;
    logic             pending;
    logic             phase;
    logic             tick;
    logic             evt;

    function automatic logic [NUM_LEDS-1:0] one_hot(input logic [SEL_W-1:0] idx);
        logic [NUM_LEDS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (idx == SEL_W'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Out-of-range selects clamp to the last LED; a zero rate behaves as one tick.
    assign sel_eff       = (32'(cmd_sel) >= 32'(NUM_LEDS)) ? LAST_LED : cmd_sel;
    assign rate_eff      = (cmd_rate == 4'd0) ? 4'd1 : cmd_rate;
    assign tick          = (prescaler == TICK_LAST);
    assign evt           = tick && (rate_cnt == act_rate - 4'd1);
    assign next_position = (position == LAST_LED) ? '0 : position + 1'b1;
    assign mode_o        = act_mode;

    // Capture at the accept edge, apply one edge later; apply always beats a
    // coincident pattern event so a new command restarts cleanly.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cmd_ready <= 1'b0;
            pending   <= 1'b0;
            cap_mode  <= MODE_OFF;
            cap_sel   <= '0;
            cap_rate  <= 4'd1;
            act_mode  <= MODE_OFF;
            act_sel   <= '0;
            act_rate  <= 4'd1;
            prescaler <= '0;
            rate_cnt  <= '0;
            phase     <= 1'b0;
            position  <= '0;
            led       <= '0;
        end else begin
            if (pending) begin
                pending   <= 1'b0;
                cmd_ready <= 1'b1;
                act_mode  <= cap_mode;
                act_sel   <= cap_sel;
                act_rate  <= cap_rate;
                prescaler <= '0;
                rate_cnt  <= '0;
                phase     <= 1'b1;
                position  <= cap_sel;
                led       <= (cap_mode == MODE_OFF) ? '0 : one_hot(cap_sel);
            end else begin
                if (cmd_valid && cmd_ready) begin
                    pending   <= 1'b1;
                    cmd_ready <= 1'b0;
                    cap_mode  <= mode_t'(cmd_mode);
                    cap_sel   <= sel_eff;
                    cap_rate  <= rate_eff;
                end else begin
                    cmd_ready <= 1'b1;
                end

                prescaler <= tick ? '0 : prescaler + 32'd1;
                if (tick) rate_cnt <= evt ? 4'd0 : rate_cnt + 4'd1;

                if (evt) begin
                    case (act_mode)
                        MODE_BLINK: begin
                            phase <= ~phase;
                            led   <= phase ? '0 : one_hot(act_sel);
                        end
                        MODE_CHASE: begin
                            position <= next_position;
                            led      <= one_hot(next_position);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Parametrised multi-channel LED pattern engine. It takes mode/select/rate commands over a valid/ready handshake and drives NUM_LEDS outputs in one of four patterns: OFF, SOLID, BLINK, CHASE.
- All pattern timing comes from an internal prescaler on clk, so there is no second clock domain.
- It sits between the fabric command interface and the board LED pins.

Parameters:
- NUM_LEDS, 4, number of LED outputs (legal range 2..16).
- TICK_DIV, 50000000, clk cycles per base tick (legal range 2..2^32-1).
- SEL_W, $clog2(NUM_LEDS), width of the LED-select field.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  block can accept a command.
- cmd_mode  in  2  00 OFF, 01 SOLID, 10 BLINK, 11 CHASE.
- cmd_sel  in  SEL_W  target LED index (CHASE: start index).
- cmd_rate  in  4  half-period or step interval, in base ticks.
- led  out  NUM_LEDS  LED drive, 1 = on.
- mode_o  out  2  currently active mode.

Behaviour:
- Reset (rstn=0 at posedge): led=0, mode_o=00, cmd_ready=0, prescaler=0, rate_cnt=0, phase=0, position=0.
  - cmd_ready rises at the first posedge with rstn=1.
- Handshake:
  - A command is accepted on a posedge where cmd_valid && cmd_ready (accept edge A). Fields are captured at A.
  - cmd_ready is low for exactly one cycle after A (from edge A to edge A+1), then high again.
  - cmd_valid with cmd_ready=0 is ignored; the source must hold the command.
- Apply (edge A+1):
  - active mode/sel/rate <= captured values; mode_o updates.
  - prescaler, rate_cnt <= 0.
  - led updates at this same edge, giving latency 1 cycle from acceptance.
- Effective values:
  - cmd_sel >= NUM_LEDS is clamped to NUM_LEDS-1.
  - cmd_rate=0 is treated as 1.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick is asserted in the cycle where prescaler == TICK_DIV-1.
- Rate counter:
  - Increments on tick.
  - Event fires when tick && rate_cnt == rate-1; rate_cnt then wraps to 0.
  - The first event after apply edge P lands exactly on edge P + TICK_DIV*rate; events repeat every TICK_DIV*rate cycles.
- Modes:
  - OFF: led=0. Counters keep running; events have no effect.
  - SOLID: led = one-hot(sel). Events have no effect.
  - BLINK: apply sets phase=1, led=one-hot(sel). Each event toggles phase; led = phase ? one-hot(sel) : 0. Non-selected LEDs are always 0.
  - CHASE: apply sets position=sel, led=one-hot(sel). Each event advances position by 1, wrapping from NUM_LEDS-1 to 0 (also for non-power-of-2 NUM_LEDS).
- Edge cases:
  - New command while a pattern is running: the pattern is aborted at the apply edge with no glitch; the new pattern restarts from its initial state and its timing restarts from zero.
  - Same command re-sent: treated as a restart (phase, position and counters reset).
  - An event coinciding with an apply edge: apply wins and the event is discarded.
  - rstn asserted mid-pattern or mid-handshake: reset values at that edge; any captured, not-yet-applied command is dropped.
- led is always registered, and at most one bit is ever set.

Test Plan:
- Reset release, TICK_DIV=4: cmd_ready=0 while rstn=0, 1 one cycle after release; led=0000, mode_o=00.
- SOLID, sel=2, NUM_LEDS=4: accept at edge A -> cmd_ready=0 during the following cycle; led=0100 and mode_o=01 at edge A+1; stable for 100 cycles.
- BLINK, sel=1, rate=2, TICK_DIV=4: led=0010 at apply edge P, 0000 at P+8, 0010 at P+16; period 16 cycles; no other bits set.
- CHASE, sel=3, rate=1, TICK_DIV=4, NUM_LEDS=5: led=01000 at P, 10000 at P+4, 00001 at P+8 (wrap), then 00010.
- Edge cases:
  - cmd_sel=7 with NUM_LEDS=5 -> led=10000.
  - cmd_rate=0 in BLINK -> toggles every 4 cycles.
  - BLINK re-commanded mid-off-phase -> led=on at the new apply edge, next toggle 8 cycles later (rate=2).
- rstn pulled low one cycle after a CHASE accept -> led=0, mode_o=00, the command is not applied, and cmd_ready returns to 1 after release.
